// File: rtl/dht_sfr_if.sv
// DW8051 SFR bus between the CPU (master) and a peripheral (slave), plus the peripheral's interrupt line.
interface dht_sfr_if;
    logic [7:0] sfr_addr;
    logic       sfr_rd;
    logic       sfr_wr;
    logic [7:0] sfr_data_in;
    logic [7:0] sfr_data_out;
    logic       irq;

    modport master (
        output sfr_addr, sfr_rd, sfr_wr, sfr_data_in,
        input  sfr_data_out, irq
    );

    modport slave (
        input  sfr_addr, sfr_rd, sfr_wr, sfr_data_in,
        output sfr_data_out, irq
    );
endinterface

// File: rtl/dht_sfr_master.sv
// AM2302/DHT single-wire master on the SFR bus. Reads are combinational, and writes take effect at the next clock.
// There is no backpressure: a start written while busy is dropped. Optional auto-polling is enabled by DHT_AUTOPOLL_EN.
module dht_sfr_master #(
    parameter int         CLK_HZ     = 36_900_000,
    parameter logic [7:0] SFR_BASE   = 8'hE1,
    parameter int         T_START_US = 1000,
    parameter int         T_BIT1_US  = 48,
    parameter int         T_TO_US    = 200
`ifdef DHT_AUTOPOLL_EN
   ,parameter int         POLL_MS    = 2000
`endif
) (
    input  logic     clk,
    input  logic     rst_n,
    dht_sfr_if.slave sfr,
    inout  wire      sda
);
    localparam int CYC_US    = CLK_HZ / 1_000_000;
    localparam int START_CYC = T_START_US * CYC_US;
    localparam int BIT1_CYC  = T_BIT1_US * CYC_US;
    localparam int TO_CYC    = T_TO_US * CYC_US;
    localparam int CNT_MAX   = (START_CYC > TO_CYC) ? START_CYC : TO_CYC;
    localparam int CW        = $clog2(CNT_MAX + 1) + 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START_LOW = 3'd1;
    localparam logic [2:0] RELEASE   = 3'd2;
    localparam logic [2:0] RESP_LOW  = 3'd3;
    localparam logic [2:0] RESP_HIGH = 3'd4;
    localparam logic [2:0] BIT_LOW   = 3'd5;
    localparam logic [2:0] BIT_HIGH  = 3'd6;
    localparam logic [2:0] CHECK     = 3'd7;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [5:0]    r_idx;
    logic [39:0]   r_shift;
    logic          r_sda_oe;
    logic [1:0]    r_sync;
    logic          r_sda_d;
    logic          r_busy, r_done, r_chk_err, r_to_err, r_ie;
    logic [7:0]    r_hum_h, r_hum_l, r_tmp_h, r_tmp_l, r_chk;

    logic       w_sda_s, w_rise, w_fall, w_edge, w_wait, w_timeout, w_cnt_sat;
    logic       w_sel_ctrl, w_wr_ctrl, w_rd_ctrl, w_start, w_auto_rd;
    logic [7:0] w_sum;

    // Open drain: the pad is only ever pulled low or left to the external pull-up.
    assign sda = r_sda_oe ? 1'b0 : 1'bz;

    assign w_sda_s    = r_sync[1];
    assign w_rise     = w_sda_s & ~r_sda_d;
    assign w_fall     = ~w_sda_s & r_sda_d;
    assign w_cnt_sat  = &r_cnt;
    assign w_timeout  = (r_cnt >= CW'(TO_CYC));
    assign w_sel_ctrl = (sfr.sfr_addr == SFR_BASE);
    assign w_wr_ctrl  = sfr.sfr_wr & w_sel_ctrl;
    assign w_rd_ctrl  = sfr.sfr_rd & w_sel_ctrl;
    assign w_sum      = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];

    always_comb begin
        w_wait = 1'b1;
        w_edge = 1'b0;
        case (r_state)
            RELEASE, RESP_HIGH, BIT_HIGH: w_edge = w_fall;
            RESP_LOW, BIT_LOW:            w_edge = w_rise;
            default:                      w_wait = 1'b0;
        endcase
    end

`ifdef DHT_AUTOPOLL_EN
    localparam int MS_CYC = CLK_HZ / 1000;
    logic        r_auto;
    logic        r_poll_tick;
    logic [31:0] r_ms_cnt, r_poll_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ms_cnt    <= '0;
            r_poll_cnt  <= '0;
            r_poll_tick <= 1'b0;
        end else begin
            r_poll_tick <= 1'b0;
            if (r_ms_cnt == 32'(MS_CYC - 1)) begin
                r_ms_cnt <= '0;
                if (r_poll_cnt == 32'(POLL_MS - 1)) begin
                    r_poll_cnt  <= '0;
                    r_poll_tick <= 1'b1;
                end else begin
                    r_poll_cnt <= r_poll_cnt + 32'd1;
                end
            end else begin
                r_ms_cnt <= r_ms_cnt + 32'd1;
            end
        end
    end

    assign w_start   = (w_wr_ctrl & sfr.sfr_data_in[0]) | (r_auto & r_poll_tick);
    assign w_auto_rd = r_auto;
`else
    assign w_start   = w_wr_ctrl & sfr.sfr_data_in[0];
    assign w_auto_rd = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_sda_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], sda};
            r_sda_d <= w_sda_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_chk_err <= 1'b0;
            r_to_err  <= 1'b0;
            r_ie      <= 1'b0;
            r_hum_h   <= '0;
            r_hum_l   <= '0;
            r_tmp_h   <= '0;
            r_tmp_l   <= '0;
            r_chk     <= '0;
`ifdef DHT_AUTOPOLL_EN
            r_auto    <= 1'b0;
`endif
        end else begin
            if (w_wr_ctrl) begin
                r_ie <= sfr.sfr_data_in[1];
`ifdef DHT_AUTOPOLL_EN
                r_auto <= sfr.sfr_data_in[2];
`endif
            end
            // A status read acknowledges done; a completion in the same cycle re-sets it below.
            if (w_rd_ctrl)
                r_done <= 1'b0;
            if (!w_cnt_sat)
                r_cnt <= r_cnt + 1'b1;

            if (r_state == IDLE) begin
                if (w_start) begin
                    r_state   <= START_LOW;
                    r_busy    <= 1'b1;
                    r_done    <= 1'b0;
                    r_chk_err <= 1'b0;
                    r_to_err  <= 1'b0;
                    r_sda_oe  <= 1'b1;
                    r_cnt     <= '0;
                end
            end else if (r_state == START_LOW) begin
                if (r_cnt == CW'(START_CYC - 1)) begin
                    r_state  <= RELEASE;
                    r_sda_oe <= 1'b0;
                    r_cnt    <= '0;
                end
            end else if (r_state == CHECK) begin
                r_hum_h   <= r_shift[39:32];
                r_hum_l   <= r_shift[31:24];
                r_tmp_h   <= r_shift[23:16];
                r_tmp_l   <= r_shift[15:8];
                r_chk     <= r_shift[7:0];
                r_chk_err <= (w_sum != r_shift[7:0]);
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= IDLE;
                r_cnt     <= '0;
            end else if (w_wait && w_edge) begin
                r_cnt <= '0;
                case (r_state)
                    RELEASE:   r_state <= RESP_LOW;
                    RESP_LOW:  r_state <= RESP_HIGH;
                    RESP_HIGH: begin
                        r_state <= BIT_LOW;
                        r_idx   <= '0;
                    end
                    BIT_LOW:   r_state <= BIT_HIGH;
                    default: begin
                        r_shift <= {r_shift[38:0], (r_cnt >= CW'(BIT1_CYC))};
                        if (r_idx == 6'd39) begin
                            r_state <= CHECK;
                        end else begin
                            r_idx   <= r_idx + 6'd1;
                            r_state <= BIT_LOW;
                        end
                    end
                endcase
            end else if (w_wait && w_timeout) begin
                r_to_err <= 1'b1;
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
                r_state  <= IDLE;
                r_cnt    <= '0;
            end
        end
    end

    always_comb begin
        sfr.sfr_data_out = 8'h00;
        if (sfr.sfr_rd) begin
            case (sfr.sfr_addr)
                SFR_BASE:         sfr.sfr_data_out = {r_ie, w_auto_rd, 2'b00, r_to_err, r_chk_err, r_done, r_busy};
                SFR_BASE + 8'd1:  sfr.sfr_data_out = r_hum_h;
                SFR_BASE + 8'd2:  sfr.sfr_data_out = r_hum_l;
                SFR_BASE + 8'd3:  sfr.sfr_data_out = r_tmp_h;
                SFR_BASE + 8'd4:  sfr.sfr_data_out = r_tmp_l;
                SFR_BASE + 8'd5:  sfr.sfr_data_out = r_chk;
                default:          sfr.sfr_data_out = 8'h00;
            endcase
        end
    end

    assign sfr.irq = r_done & r_ie;
endmodule

// File: tb/tb_dht_sfr_master.sv
// Directed bench for dht_sfr_master at CLK_HZ=1 MHz with a behavioural AM2302 sensor on the open-drain line.
module tb_dht_sfr_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dht_sfr_if bus();
    wire  sda;
    logic sens_low = 1'b0;
    logic sens_done = 1'b1;
    int   sens_bit = -1;

    assign sda = sens_low ? 1'b0 : 1'bz;
    pullup (sda);

    dht_sfr_master #(.CLK_HZ(1_000_000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sfr   (bus),
        .sda   (sda)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sfr_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.sfr_addr    = addr;
        bus.sfr_data_in = data;
        bus.sfr_wr      = 1'b1;
        @(negedge clk);
        bus.sfr_wr      = 1'b0;
    endtask

    task automatic sfr_read(input logic [7:0] addr, output logic [7:0] data);
        @(negedge clk);
        bus.sfr_addr = addr;
        bus.sfr_rd   = 1'b1;
        #1 data = bus.sfr_data_out;
        @(negedge clk);
        bus.sfr_rd   = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        sfr_read(addr, d);
        check(tag, {24'h0, d}, {24'h0, exp});
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (sda === 1'b0 && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // 20 us turnaround, 80/80 us response, 50 us bit lows, 26/70 us bit highs, 50 us trailing low.
    task automatic sensor_run(input logic [39:0] bits);
        int t;
        sens_done = 1'b0;
        sens_bit  = -1;
        t = 0;
        while (sda !== 1'b0 && t < 5000) begin t++; @(negedge clk); end
        t = 0;
        while (sda !== 1'b1 && t < 5000) begin t++; @(negedge clk); end
        repeat (20) @(negedge clk);
        sens_low = 1'b1; repeat (80) @(negedge clk);
        sens_low = 1'b0; repeat (80) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            sens_bit = i;
            sens_low = 1'b1; repeat (50) @(negedge clk);
            sens_low = 1'b0; repeat (bits[39-i] ? 70 : 26) @(negedge clk);
        end
        sens_low = 1'b1; repeat (50) @(negedge clk);
        sens_low  = 1'b0;
        sens_bit  = 40;
        sens_done = 1'b1;
    endtask

    task automatic wait_sensor(input string tag);
        int t;
        t = 0;
        while (!sens_done && t < 20000) begin t++; @(negedge clk); end
        check(tag, {31'h0, sens_done}, 32'h1);
        repeat (10) @(negedge clk);
    endtask

    task automatic check_data(input string tag, input logic [39:0] exp);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            b = exp[39 - 8*i -: 8];
            read_check($sformatf("%s_E%0h", tag, 8'hE2 + i), 8'hE2 + 8'(i), b);
        end
    endtask

    initial begin
        int n;
        int t;
        logic [39:0] good, bad, alt;
        good = 40'h02_8C_01_5F_EE;
        bad  = 40'h02_8C_01_5F_EF;
        alt  = 40'h35_00_00_F1_26;
        bus.sfr_addr    = 8'h00;
        bus.sfr_rd      = 1'b0;
        bus.sfr_wr      = 1'b0;
        bus.sfr_data_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("reset_sda", {31'h0, sda}, 32'h1);
        check("reset_irq", {31'h0, bus.irq}, 32'h0);
        read_check("reset_stat", 8'hE1, 8'h00);
        read_check("reset_hum_h", 8'hE2, 8'h00);
        read_check("unmapped", 8'hE7, 8'h00);

        // Start pulse width, then a clean transfer.
        fork sensor_run(good); join_none
        sfr_write(8'hE1, 8'h01);
        measure_low(n);
        check("start_low_cycles", n, 1000);
        read_check("busy_after_release", 8'hE1, 8'h01);
        wait_sensor("sensor_good");
        read_check("stat_good", 8'hE1, 8'h02);
        read_check("stat_done_cleared", 8'hE1, 8'h00);
        check_data("good", good);

        // Bad checksum still loads the data.
        fork sensor_run(bad); join_none
        sfr_write(8'hE1, 8'h01);
        wait_sensor("sensor_bad");
        read_check("stat_chk_err", 8'hE1, 8'h06);
        check_data("bad", bad);

        // No sensor: timeout 200 cycles into RELEASE, data kept.
        sfr_write(8'hE1, 8'h01);
        measure_low(n);
        check("start_low_cycles_to", n, 1000);
        repeat (150) @(negedge clk);
        read_check("stat_before_to", 8'hE1, 8'h01);
        repeat (100) @(negedge clk);
        read_check("stat_to_err", 8'hE1, 8'h0A);
        check_data("kept", bad);

        // Interrupt, and a start while busy must not restart the low pulse.
        fork sensor_run(good); join_none
        sfr_write(8'hE1, 8'h03);
        repeat (500) @(negedge clk);
        sfr_write(8'hE1, 8'h03);
        measure_low(n);
        check("low_after_busy_start", n, 498);
        wait_sensor("sensor_irq");
        check("irq_set", {31'h0, bus.irq}, 32'h1);
        read_check("stat_irq", 8'hE1, 8'h82);
        check("irq_cleared", {31'h0, bus.irq}, 32'h0);
        read_check("irq_chk_byte", 8'hE6, 8'hEE);

        // Reset during the high phase of bit 17.
        fork sensor_run(good); join_none
        sfr_write(8'hE1, 8'h03);
        t = 0;
        while (!(sens_bit == 17 && sens_low == 1'b0) && t < 20000) begin t++; @(negedge clk); end
        check("reached_bit17", sens_bit, 17);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_sda_released", {31'h0, sda}, 32'h1);
        check("rst_irq", {31'h0, bus.irq}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        read_check("rst_stat", 8'hE1, 8'h00);
        read_check("rst_data", 8'hE2, 8'h00);
        wait_sensor("sensor_interrupted");

        fork sensor_run(alt); join_none
        sfr_write(8'hE1, 8'h01);
        wait_sensor("sensor_alt");
        read_check("stat_alt", 8'hE1, 8'h02);
        check_data("alt", alt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
